// File: rtl/hd44780_refresh_seq.sv
// Drives one full clock-line refresh (address, HH:MM:SS, A/P) through the
// HD44780 formatter, handing each formatted byte to the LCD driver via valid/ready.
//
// state | meaning
// IDLE  | waiting for a start request or a pending restart
// ISSUE | one-cycle formatter enable with the current item's fields
// WRITE | write valid held until the LCD driver accepts the byte
// DONE  | one-cycle completion pulse
module hd44780_refresh_seq #(
  parameter logic       LINE = 1'b0,
  parameter logic [3:0] COL  = 4'h4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [23:0] i_time,
  input  logic        i_pm,
  output logic        o_ena,
  output logic        o_data,
  output logic [1:0]  o_sel,
  output logic [3:0]  o_d,
  output logic        o_wr,
  output logic        o_rs,
  input  logic        i_ready,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  idx;
  logic        pending;
  logic [23:0] snap_time;
  logic        snap_pm;
  logic        item_data;
  logic [1:0]  item_sel;
  logic [3:0]  item_d;
  logic        hold_data;
  logic [1:0]  hold_sel;
  logic [3:0]  hold_d;
  logic        rs_q;
  logic        take;
  logic        last;

  assign take = (state == S_IDLE) && (i_start || pending);
  assign last = (idx == 4'd9);

  // 4'hA on a character item renders as ':' in the formatter
  always_comb begin
    item_data = 1'b1;
    item_sel  = 2'b00;
    item_d    = 4'h0;
    case (idx)
      4'd0: begin
        item_data = 1'b0;
        item_sel  = {1'b0, LINE};
        item_d    = COL;
      end
      4'd1:    item_d = snap_time[23:20];
      4'd2:    item_d = snap_time[19:16];
      4'd3:    item_d = 4'hA;
      4'd4:    item_d = snap_time[15:12];
      4'd5:    item_d = snap_time[11:8];
      4'd6:    item_d = 4'hA;
      4'd7:    item_d = snap_time[7:4];
      4'd8:    item_d = snap_time[3:0];
      default: begin
        item_sel = 2'b11;
        item_d   = {3'b000, snap_pm};
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    o_ena    = 1'b0;
    o_wr     = 1'b0;
    o_done   = 1'b0;
    o_data   = hold_data;
    o_sel    = hold_sel;
    o_d      = hold_d;
    case (state)
      S_IDLE: begin
        if (take) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        o_ena    = 1'b1;
        o_data   = item_data;
        o_sel    = item_sel;
        o_d      = item_d;
        state_nx = S_WRITE;
      end
      S_WRITE: begin
        o_wr = 1'b1;
        if (i_ready) state_nx = last ? S_DONE : S_ISSUE;
      end
      default: begin
        o_done   = 1'b1;
        state_nx = S_IDLE;
      end
    endcase
  end

  assign o_busy = (state != S_IDLE);
  assign o_rs   = rs_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      pending   <= 1'b0;
      snap_time <= 24'h0;
      snap_pm   <= 1'b0;
      hold_data <= 1'b0;
      hold_sel  <= 2'b00;
      hold_d    <= 4'h0;
      rs_q      <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        snap_time <= i_time;
        snap_pm   <= i_pm;
        pending   <= 1'b0;
        idx       <= 4'd0;
      end else if (i_start && state != S_IDLE) begin
        pending <= 1'b1;
      end
      if (state == S_ISSUE) begin
        hold_data <= item_data;
        hold_sel  <= item_sel;
        hold_d    <= item_d;
        rs_q      <= item_data;
      end
      if (state == S_WRITE && i_ready && !last) idx <= idx + 4'd1;
    end
  end

endmodule

// File: tb/tb_hd44780_refresh_seq.sv
// Bench for hd44780_refresh_seq: formatter model plus expected-byte scoreboard,
// table-driven refreshes and hand-written restart/reset sequences.
module tb_hd44780_refresh_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start2, pm, ready;
  logic [23:0] tm;
  logic        ena, data, wr, rs, busy, done;
  logic [1:0]  sel;
  logic [3:0]  d;
  logic        ena2, data2, wr2, rs2, busy2, done2;
  logic [1:0]  sel2;
  logic [3:0]  d2;

  hd44780_refresh_seq u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_time(tm), .i_pm(pm),
    .o_ena(ena), .o_data(data), .o_sel(sel), .o_d(d), .o_wr(wr), .o_rs(rs),
    .i_ready(ready), .o_busy(busy), .o_done(done)
  );

  hd44780_refresh_seq #(.LINE(1'b1), .COL(4'h0)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_time(tm), .i_pm(pm),
    .o_ena(ena2), .o_data(data2), .o_sel(sel2), .o_d(d2), .o_wr(wr2), .o_rs(rs2),
    .i_ready(ready), .o_busy(busy2), .o_done(done2)
  );

  typedef struct {
    logic [7:0] b;
    logic       rs;
  } exp_t;

  typedef struct {
    logic [23:0] tm;
    logic        pm;
    int          stall_item;
    int          stall_len;
    int          chg_item;
    logic [23:0] chg_tm;
    int          exp_lat;
  } vec_t;

  exp_t q[$];
  exp_t e_pop;
  vec_t vecs[4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0, base, d0, e0, x0;
  int cur_item = -1;
  int ena_cnt = 0;
  int wr_hi = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int xfer_cnt = 0;
  int stall_chk_item = -1;
  int stall_chk_len = 0;
  logic [7:0] fmt = 8'h0;
  logic [6:0] ena_d = 7'h0;
  logic [7:0] fmt2 = 8'h0;
  logic [7:0] got2[10];
  logic       gotrs2[10];
  int n2 = 0;
  int done2_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s got=timeout want=event", name);
  endtask

  // Byte the HD44780 formatter would produce for a given set of controls
  function automatic logic [7:0] fmt_fn(input logic dt, input logic [1:0] s, input logic [3:0] n);
    if (!dt) return (s[0] ? 8'hC0 : 8'h80) | {4'h0, n};
    else if (s == 2'b11) return n[0] ? 8'h50 : 8'h41;
    else return {4'h3, n};
  endfunction

  function automatic logic [7:0] exp_byte(input int k, input logic [23:0] t, input logic p,
                                          input logic line, input logic [3:0] col);
    case (k)
      0: return (line ? 8'hC0 : 8'h80) | {4'h0, col};
      1: return {4'h3, t[23:20]};
      2: return {4'h3, t[19:16]};
      3: return 8'h3A;
      4: return {4'h3, t[15:12]};
      5: return {4'h3, t[11:8]};
      6: return 8'h3A;
      7: return {4'h3, t[7:4]};
      8: return {4'h3, t[3:0]};
      default: return p ? 8'h50 : 8'h41;
    endcase
  endfunction

  task automatic push_refresh(input logic [23:0] t, input logic p);
    for (int k = 0; k < 10; k++) q.push_back('{b: exp_byte(k, t, p, 1'b0, 4'h4), rs: (k != 0)});
  endtask

  always @(negedge clk) begin
    if (wr) begin
      wr_hi++;
      if (!ready) chk("stall_hold", {25'h0, data, sel, d}, {25'h0, ena_d});
      else begin
        xfer_cnt++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write got=%0h want=none", fmt);
        end else begin
          e_pop = q.pop_front();
          chk("byte", {24'h0, fmt}, {24'h0, e_pop.b});
          chk("rs", {31'h0, rs}, {31'h0, e_pop.rs});
        end
        if (cur_item == stall_chk_item) chk("stall_len", wr_hi, stall_chk_len + 1);
      end
    end
    if (ena) begin
      fmt      = fmt_fn(data, sel, d);
      ena_d    = {data, sel, d};
      cur_item = ena_cnt;
      ena_cnt++;
      wr_hi    = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (wr2 && ready) begin
      if (n2 < 10) begin
        got2[n2]   = fmt2;
        gotrs2[n2] = rs2;
      end
      n2++;
    end
    if (ena2) fmt2 = fmt_fn(data2, sel2, d2);
    if (done2) done2_cnt++;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_item(input int k);
    int n = 0;
    while (!(wr && cur_item == base + k) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) timeout("wait_item");
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) timeout("wait_done");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{tm: 24'h123456, pm: 1'b1, stall_item: -1, stall_len: 0, chg_item: -1, chg_tm: 24'h0,      exp_lat: 21};
    vecs[1] = '{tm: 24'h123456, pm: 1'b1, stall_item: 4,  stall_len: 5, chg_item: -1, chg_tm: 24'h0,      exp_lat: 26};
    vecs[2] = '{tm: 24'h123456, pm: 1'b1, stall_item: -1, stall_len: 0, chg_item: 3,  chg_tm: 24'h235959, exp_lat: 21};
    vecs[3] = '{tm: 24'h09FA05, pm: 1'b0, stall_item: -1, stall_len: 0, chg_item: -1, chg_tm: 24'h0,      exp_lat: 21};

    rst = 1'b1; start = 1'b0; start2 = 1'b0; pm = 1'b0; tm = 24'h0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {23'h0, ena, data, sel, d, wr, rs, busy, done}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      tm = vecs[i].tm;
      pm = vecs[i].pm;
      @(posedge clk); #1;
      base = ena_cnt;
      push_refresh(vecs[i].tm, vecs[i].pm);
      stall_chk_item = (vecs[i].stall_item >= 0) ? base + vecs[i].stall_item : -1;
      stall_chk_len  = vecs[i].stall_len;
      d0 = done_cnt;
      t0 = cyc;
      pulse_start();
      if (vecs[i].chg_item >= 0) begin
        wait_item(vecs[i].chg_item);
        tm = vecs[i].chg_tm;
      end
      if (vecs[i].stall_item >= 0) begin
        wait_item(vecs[i].stall_item);
        ready = 1'b0;
        repeat (vecs[i].stall_len) begin
          @(posedge clk); #1;
        end
        ready = 1'b1;
      end
      wait_done(d0 + 1);
      chk("done_lat", done_cyc - t0, vecs[i].exp_lat);
      chk("busy_after", {31'h0, busy}, 32'h0);
      chk("queue_empty", q.size(), 0);
    end
    stall_chk_item = -1;

    // Second line, column 0, AM
    tm = 24'h101010;
    pm = 1'b0;
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int n = 0; n < 200 && done2_cnt < 1; n++) begin
      @(posedge clk); #1;
    end
    chk("dut2_done", done2_cnt, 1);
    chk("dut2_writes", n2, 10);
    for (int k = 0; k < 10; k++) begin
      chk("dut2_byte", {24'h0, got2[k]}, {24'h0, exp_byte(k, 24'h101010, 1'b0, 1'b1, 4'h0)});
      chk("dut2_rs", {31'h0, gotrs2[k]}, (k != 0) ? 32'h1 : 32'h0);
    end

    // Three requests during a refresh collapse into one restart
    tm = 24'h123456;
    pm = 1'b1;
    @(posedge clk); #1;
    base = ena_cnt;
    push_refresh(24'h123456, 1'b1);
    push_refresh(24'h010203, 1'b0);
    d0 = done_cnt;
    t0 = cyc;
    pulse_start();
    wait_item(2);
    pulse_start();
    wait_item(5);
    tm = 24'h010203;
    pm = 1'b0;
    pulse_start();
    wait_item(8);
    pulse_start();
    wait_done(d0 + 2);
    chk("restart_lat", done_cyc - t0, 43);
    repeat (30) @(posedge clk);
    #1;
    chk("restart_done_count", done_cnt - d0, 2);
    chk("restart_queue_empty", q.size(), 0);

    // Reset during the write of item 6 aborts the refresh
    tm = 24'h112233;
    pm = 1'b1;
    @(posedge clk); #1;
    base = ena_cnt;
    push_refresh(24'h112233, 1'b1);
    pulse_start();
    wait_item(6);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", {23'h0, ena, data, sel, d, wr, rs, busy, done}, 32'h0);
    rst = 1'b0;
    q.delete();
    e0 = ena_cnt;
    x0 = xfer_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_ena", ena_cnt - e0, 0);
    chk("abort_no_wr", xfer_cnt - x0, 0);
    chk("abort_idle", {31'h0, busy}, 32'h0);

    // Fresh start after the abort runs a complete refresh
    tm = 24'h075900;
    pm = 1'b0;
    @(posedge clk); #1;
    base = ena_cnt;
    push_refresh(24'h075900, 1'b0);
    d0 = done_cnt;
    t0 = cyc;
    pulse_start();
    wait_done(d0 + 1);
    chk("recover_lat", done_cyc - t0, 21);
    chk("recover_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
